// File: rtl/pc_seq_pkg.sv
// rtl/pc_seq_pkg.sv - pc_op encoding, op width and decode helper for pc_seq
// Shared by pc_seq and pc_seq_ras; call/ret decode depends on PC_SEQ_RAS_EN at the top.
package pc_seq_pkg;

   localparam int PC_OP_W = 3;

   typedef enum logic [PC_OP_W-1:0] {
      OP_NOP  = 3'b000,
      OP_INC  = 3'b001,
      OP_DEC  = 3'b010,
      OP_SET  = 3'b011,
      OP_ADD  = 3'b100,
      OP_CALL = 3'b101,
      OP_RET  = 3'b110,
      OP_RSVD = 3'b111
   } pc_op_e;

   // nop and reserved never count as accepted; call/ret only when the stack exists
   function automatic logic op_is_active(input pc_op_e op, input logic ras_en);
      case (op)
         OP_INC, OP_DEC, OP_SET, OP_ADD: op_is_active = 1'b1;
         OP_CALL, OP_RET:                op_is_active = ras_en;
         default:                        op_is_active = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/pc_seq_ras.sv
// rtl/pc_seq_ras.sv - circular return-address stack for pc_seq
// A push on a full stack overwrites the oldest entry; overflow/underflow are one-cycle pulses.
module pc_seq_ras
   import pc_seq_pkg::*;
#(
   parameter int ADDR_W    = 32,
   parameter int RAS_DEPTH = 8
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         push,
   input  logic                         pop,
   input  logic [ADDR_W-1:0]            push_addr,
   output logic [ADDR_W-1:0]            top_addr,
   output logic [$clog2(RAS_DEPTH):0]   count,
   output logic                         empty,
   output logic                         overflow,
   output logic                         underflow
);

   localparam int PTR_W = $clog2(RAS_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [ADDR_W-1:0] mem [RAS_DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  top_ptr;
   logic              full;

   // wr_ptr is the next free slot; when full it also points at the oldest entry
   assign top_ptr  = wr_ptr - PTR_W'(1);
   assign top_addr = mem[top_ptr];
   assign empty    = (count == '0);
   assign full     = (count == CNT_W'(RAS_DEPTH));

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= push_addr;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr    <= '0;
         count     <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
            if (full) begin
               overflow <= 1'b1;
            end else begin
               count <= count + CNT_W'(1);
            end
         end else if (pop) begin
            if (empty) begin
               underflow <= 1'b1;
            end else begin
               wr_ptr <= top_ptr;
               count  <= count - CNT_W'(1);
            end
         end
      end
   end

endmodule

// File: rtl/pc_seq.sv
// rtl/pc_seq.sv - program-counter sequencer with valid/ready fetch handshake
// Define PC_SEQ_RAS_EN to build the return-address stack and enable call/ret.
module pc_seq
   import pc_seq_pkg::*;
#(
   parameter int                ADDR_W     = 32,
   parameter int                STEP       = 1,
   parameter logic [ADDR_W-1:0] RESET_ADDR = '0,
   parameter int                RAS_DEPTH  = 8
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [PC_OP_W-1:0]           pc_op,
   input  logic [ADDR_W-1:0]            pc_arg,
   output logic                         op_ready,
   output logic [ADDR_W-1:0]            pc_addr,
   output logic                         fetch_valid,
   input  logic                         fetch_ready,
   output logic [$clog2(RAS_DEPTH):0]   ras_count,
   output logic                         ras_overflow,
   output logic                         ras_underflow
);

`ifdef PC_SEQ_RAS_EN
   localparam logic RAS_EN = 1'b1;
`else
   localparam logic RAS_EN = 1'b0;
`endif

   localparam logic [ADDR_W-1:0] STEP_V = ADDR_W'(STEP);

   pc_op_e            op;
   logic              accept;
   logic [ADDR_W-1:0] pc_nxt;
   logic              fv_nxt;

   assign op       = pc_op_e'(pc_op);
   assign op_ready = !fetch_valid | fetch_ready;
   assign accept   = op_ready & op_is_active(op, RAS_EN);

`ifdef PC_SEQ_RAS_EN
   logic              ras_push;
   logic              ras_pop;
   logic              ras_empty;
   logic [ADDR_W-1:0] ras_top;
   logic [ADDR_W-1:0] ret_addr;

   assign ret_addr = pc_addr + STEP_V;

   pc_seq_ras #(
      .ADDR_W    (ADDR_W),
      .RAS_DEPTH (RAS_DEPTH)
   ) u_ras (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (ras_push),
      .pop       (ras_pop),
      .push_addr (ret_addr),
      .top_addr  (ras_top),
      .count     (ras_count),
      .empty     (ras_empty),
      .overflow  (ras_overflow),
      .underflow (ras_underflow)
   );
`else
   assign ras_count     = '0;
   assign ras_overflow  = 1'b0;
   assign ras_underflow = 1'b0;
`endif

   // Default: hold address, drop the request once the fetch stage has taken it
   always_comb begin
      pc_nxt = pc_addr;
      fv_nxt = fetch_valid & ~fetch_ready;
`ifdef PC_SEQ_RAS_EN
      ras_push = 1'b0;
      ras_pop  = 1'b0;
`endif
      if (accept) begin
         case (op)
            OP_INC: begin
               pc_nxt = pc_addr + STEP_V;
               fv_nxt = 1'b1;
            end
            OP_DEC: begin
               pc_nxt = pc_addr - STEP_V;
               fv_nxt = 1'b1;
            end
            OP_SET: begin
               pc_nxt = pc_arg;
               fv_nxt = 1'b1;
            end
            OP_ADD: begin
               pc_nxt = pc_addr + pc_arg;
               fv_nxt = 1'b1;
            end
`ifdef PC_SEQ_RAS_EN
            OP_CALL: begin
               ras_push = 1'b1;
               pc_nxt   = pc_arg;
               fv_nxt   = 1'b1;
            end
            OP_RET: begin
               ras_pop = 1'b1;
               // empty-stack ret makes no new request; the stack flags underflow
               if (!ras_empty) begin
                  pc_nxt = ras_top;
                  fv_nxt = 1'b1;
               end
            end
`endif
            default: begin
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_addr     <= RESET_ADDR;
         fetch_valid <= 1'b1;
      end else begin
         pc_addr     <= pc_nxt;
         fetch_valid <= fv_nxt;
      end
   end

endmodule

// File: tb/tb_pc_seq.sv
// tb/tb_pc_seq.sv - self-checking bench for pc_seq against a queue-based reference model
// Call/return scenarios are exercised only when PC_SEQ_RAS_EN is defined.
module tb_pc_seq;
   import pc_seq_pkg::*;

   localparam int              AW    = 16;
   localparam int              DEPTH = 2;
   localparam logic [AW-1:0]   RST   = 16'h0100;
   localparam logic [AW-1:0]   STEPV = 16'd4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst_n;
   logic [2:0]    pc_op;
   logic [AW-1:0] pc_arg;
   logic          fetch_ready;
   logic          op_ready;
   logic [AW-1:0] pc_addr;
   logic          fetch_valid;
   logic [1:0]    ras_count;
   logic          ras_overflow;
   logic          ras_underflow;

   logic [2:0]    b_op;
   logic [7:0]    b_arg;
   logic          b_fr;
   logic          b_op_ready;
   logic [7:0]    b_pc;
   logic          b_fv;
   logic [3:0]    b_cnt;
   logic          b_ovf;
   logic          b_unf;

   pc_seq #(.ADDR_W(AW), .STEP(4), .RESET_ADDR(RST), .RAS_DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .pc_op(pc_op), .pc_arg(pc_arg), .op_ready(op_ready),
      .pc_addr(pc_addr), .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
      .ras_count(ras_count), .ras_overflow(ras_overflow), .ras_underflow(ras_underflow)
   );

   pc_seq #(.ADDR_W(8), .STEP(4), .RESET_ADDR(8'h00), .RAS_DEPTH(8)) dut_b (
      .clk(clk), .rst_n(rst_n), .pc_op(b_op), .pc_arg(b_arg), .op_ready(b_op_ready),
      .pc_addr(b_pc), .fetch_valid(b_fv), .fetch_ready(b_fr),
      .ras_count(b_cnt), .ras_overflow(b_ovf), .ras_underflow(b_unf)
   );

   int n_cmp = 0;
   int n_err = 0;

   // reference model: address, pending flag, pulses and the stack as a plain queue
   logic [AW-1:0] m_pc;
   logic          m_fv;
   logic          m_ovf;
   logic          m_unf;
   logic [AW-1:0] m_ras [$];
   logic          s_rdy;
   logic          s_rdy_exp;

   wire [AW+4:0] dut_vec = {pc_addr, fetch_valid, ras_count, ras_overflow, ras_underflow};

   function automatic logic [AW+4:0] m_vec();
      return {m_pc, m_fv, 2'(m_ras.size()), m_ovf, m_unf};
   endfunction

   task automatic model_reset();
      m_pc  = RST;
      m_fv  = 1'b1;
      m_ovf = 1'b0;
      m_unf = 1'b0;
      m_ras.delete();
   endtask

   task automatic model_step(input logic [2:0] op, input logic [AW-1:0] arg, input logic fr);
      logic rdy;
      rdy   = !m_fv || fr;
      m_ovf = 1'b0;
      m_unf = 1'b0;
      if (m_fv && fr) m_fv = 1'b0;
      if (rdy) begin
         case (op)
            OP_INC: begin m_pc = m_pc + STEPV; m_fv = 1'b1; end
            OP_DEC: begin m_pc = m_pc - STEPV; m_fv = 1'b1; end
            OP_SET: begin m_pc = arg;          m_fv = 1'b1; end
            OP_ADD: begin m_pc = m_pc + arg;   m_fv = 1'b1; end
`ifdef PC_SEQ_RAS_EN
            OP_CALL: begin
               if (m_ras.size() == DEPTH) begin
                  m_ras.delete(0);
                  m_ovf = 1'b1;
               end
               m_ras.push_back(m_pc + STEPV);
               m_pc = arg;
               m_fv = 1'b1;
            end
            OP_RET: begin
               if (m_ras.size() == 0) m_unf = 1'b1;
               else begin
                  m_pc = m_ras.pop_back();
                  m_fv = 1'b1;
               end
            end
`endif
            default: begin end
         endcase
      end
   endtask

   task automatic step(input logic [2:0] op, input logic [AW-1:0] arg, input logic fr);
      @(negedge clk);
      pc_op       = op;
      pc_arg      = arg;
      fetch_ready = fr;
      #1;
      s_rdy     = op_ready;
      s_rdy_exp = !m_fv || fr;
      @(posedge clk);
      model_step(op, arg, fr);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; pc_op = OP_NOP; pc_arg = '0; fetch_ready = 1'b1;
      b_op = OP_NOP; b_arg = '0; b_fr = 1'b1;
      #12;
      n_cmp++;
      if (dut_vec !== {RST, 1'b1, 2'd0, 1'b0, 1'b0}) begin
         n_err++; $display("FAIL reset_state: got %h required %h", dut_vec, {RST, 1'b1, 2'd0, 1'b0, 1'b0});
      end
      n_cmp++;
      if ({b_pc, b_fv} !== {8'h00, 1'b1}) begin
         n_err++; $display("FAIL reset_state_b: got %h/%b required 00/1", b_pc, b_fv);
      end
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      #1;
      n_cmp++;
      if (op_ready !== 1'b1) begin
         n_err++; $display("FAIL reset_op_ready: got %b required 1", op_ready);
      end
   endtask

   task automatic test_inc();
      logic [AW-1:0] e;
      for (int i = 1; i <= 3; i++) begin
         step(OP_INC, '0, 1'b1);
         e = RST + AW'(4 * i);
         n_cmp++;
         if ({pc_addr, fetch_valid} !== {e, 1'b1}) begin
            n_err++; $display("FAIL inc_%0d: got %h/%b required %h/1", i, pc_addr, fetch_valid, e);
         end
         n_cmp++;
         if (dut_vec !== m_vec()) begin
            n_err++; $display("FAIL inc_model_%0d: got %h required %h", i, dut_vec, m_vec());
         end
      end
   endtask

   task automatic test_stall();
      logic [AW-1:0] held;
      held = m_pc;
      for (int i = 0; i < 5; i++) begin
         step(OP_INC, '0, 1'b0);
         n_cmp++;
         if (s_rdy !== 1'b0 || pc_addr !== held || fetch_valid !== 1'b1) begin
            n_err++; $display("FAIL stall_%0d: got rdy=%b pc=%h fv=%b required rdy=0 pc=%h fv=1",
                              i, s_rdy, pc_addr, fetch_valid, held);
         end
      end
      step(OP_INC, '0, 1'b1);
      n_cmp++;
      if (s_rdy !== 1'b1 || pc_addr !== held + STEPV) begin
         n_err++; $display("FAIL stall_release: got rdy=%b pc=%h required rdy=1 pc=%h", s_rdy, pc_addr, held + STEPV);
      end
      step(OP_NOP, '0, 1'b1);
      n_cmp++;
      if ({pc_addr, fetch_valid} !== {held + STEPV, 1'b0}) begin
         n_err++; $display("FAIL stall_single_inc: got %h/%b required %h/0", pc_addr, fetch_valid, held + STEPV);
      end
   endtask

`ifdef PC_SEQ_RAS_EN
   task automatic test_call_ret();
      logic [2:0]    ops   [3] = '{OP_SET, OP_CALL, OP_RET};
      logic [AW-1:0] args  [3] = '{16'h0020, 16'h0080, 16'h0000};
      logic [AW-1:0] e_pc  [3] = '{16'h0020, 16'h0080, 16'h0024};
      logic [1:0]    e_cnt [3] = '{2'd0, 2'd1, 2'd0};
      for (int i = 0; i < 3; i++) begin
         step(ops[i], args[i], 1'b1);
         n_cmp++;
         if ({pc_addr, fetch_valid, ras_count} !== {e_pc[i], 1'b1, e_cnt[i]}) begin
            n_err++; $display("FAIL call_ret_%0d: got %h/%b/%0d required %h/1/%0d",
                              i, pc_addr, fetch_valid, ras_count, e_pc[i], e_cnt[i]);
         end
         n_cmp++;
         if (dut_vec !== m_vec()) begin
            n_err++; $display("FAIL call_ret_model_%0d: got %h required %h", i, dut_vec, m_vec());
         end
      end
   endtask

   task automatic test_overflow();
      logic [2:0]    ops   [8] = '{OP_CALL, OP_CALL, OP_CALL, OP_NOP, OP_RET, OP_RET, OP_RET, OP_NOP};
      logic [AW-1:0] args  [8] = '{16'h0040, 16'h0050, 16'h0060, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
      logic [AW-1:0] e_pc  [8] = '{16'h0040, 16'h0050, 16'h0060, 16'h0060, 16'h0054, 16'h0044, 16'h0044, 16'h0044};
      logic          e_fv  [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      logic [1:0]    e_cnt [8] = '{2'd1, 2'd2, 2'd2, 2'd2, 2'd1, 2'd0, 2'd0, 2'd0};
      logic          e_ovf [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      logic          e_unf [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      logic [AW+4:0] e;
      for (int i = 0; i < 8; i++) begin
         step(ops[i], args[i], 1'b1);
         e = {e_pc[i], e_fv[i], e_cnt[i], e_ovf[i], e_unf[i]};
         n_cmp++;
         if (dut_vec !== e) begin
            n_err++; $display("FAIL ovf_unf_%0d: got %h required %h", i, dut_vec, e);
         end
         n_cmp++;
         if (dut_vec !== m_vec()) begin
            n_err++; $display("FAIL ovf_unf_model_%0d: got %h required %h", i, dut_vec, m_vec());
         end
      end
   endtask
`else
   task automatic test_no_ras();
      logic [AW-1:0] held;
      held = m_pc;
      step(OP_CALL, 16'h0080, 1'b1);
      step(OP_RET, '0, 1'b1);
      n_cmp++;
      if ({pc_addr, fetch_valid, ras_count, ras_overflow, ras_underflow} !== {held, 1'b0, 2'd0, 1'b0, 1'b0}) begin
         n_err++; $display("FAIL no_ras_call_ret: got %h required %h", dut_vec, {held, 1'b0, 2'd0, 1'b0, 1'b0});
      end
   endtask
`endif

   task automatic test_wrap();
      logic [2:0] ops  [4] = '{OP_SET, OP_INC, OP_SET, OP_ADD};
      logic [7:0] args [4] = '{8'hFE, 8'h00, 8'h05, 8'hF0};
      logic [7:0] e_pc [4] = '{8'hFE, 8'h02, 8'h05, 8'hF5};
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         b_op  = ops[i];
         b_arg = args[i];
         @(posedge clk);
         #1;
         n_cmp++;
         if ({b_pc, b_fv} !== {e_pc[i], 1'b1}) begin
            n_err++; $display("FAIL wrap_%0d: got %h/%b required %h/1", i, b_pc, b_fv, e_pc[i]);
         end
      end
      @(negedge clk);
      b_op = OP_NOP;
   endtask

   task automatic test_back_to_back();
      logic [2:0]    op;
      logic [AW-1:0] arg;
      logic          fr;
      for (int i = 0; i < 300; i++) begin
         op  = 3'($urandom_range(0, 7));
         arg = AW'($urandom);
         fr  = ($urandom_range(0, 3) != 0);
         step(op, arg, fr);
         n_cmp++;
         if (s_rdy !== s_rdy_exp) begin
            n_err++; $display("FAIL rand_op_ready_%0d: got %b required %b", i, s_rdy, s_rdy_exp);
         end
         n_cmp++;
         if (dut_vec !== m_vec()) begin
            n_err++; $display("FAIL rand_state_%0d: op=%0d got %h required %h", i, op, dut_vec, m_vec());
         end
      end
   endtask

   task automatic test_reset_mid_stall();
      step(OP_CALL, 16'h0300, 1'b1);
      step(OP_CALL, 16'h0400, 1'b1);
      step(OP_NOP, '0, 1'b0);
      n_cmp++;
      if (dut_vec !== m_vec()) begin
         n_err++; $display("FAIL pre_reset_state: got %h required %h", dut_vec, m_vec());
      end
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if (dut_vec !== {RST, 1'b1, 2'd0, 1'b0, 1'b0}) begin
         n_err++; $display("FAIL async_reset: got %h required %h", dut_vec, {RST, 1'b1, 2'd0, 1'b0, 1'b0});
      end
      model_reset();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      step(OP_NOP, '0, 1'b0);
      n_cmp++;
      if (dut_vec !== {RST, 1'b1, 2'd0, 1'b0, 1'b0} || dut_vec !== m_vec()) begin
         n_err++; $display("FAIL post_reset_hold: got %h required %h", dut_vec, m_vec());
      end
   endtask

   initial begin
      test_reset();
      test_inc();
      test_stall();
`ifdef PC_SEQ_RAS_EN
      test_call_ret();
      test_overflow();
`else
      test_no_ras();
`endif
      test_wrap();
      test_back_to_back();
      test_reset_mid_stall();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/pc_seq.md
# pc_seq

Parametrised program-counter sequencer for the CPU front end. It holds the current fetch address and applies increment, decrement, absolute-set, signed-relative, call and return operations. It presents each new address to the instruction-fetch stage through a valid/ready handshake. It succeeds the fixed 32-bit PC: width, step and reset vector are configurable, fetch requests are held until accepted, and a return-address stack (RAS) supports call/return.

## Interface
- ADDR_W, 32, address width in bits (≥4)
- STEP, 1, increment/decrement amount and call return offset
- RESET_ADDR, 0, pc_addr value after reset
- RAS_DEPTH, 8, return-stack entries (power of two, ≥2)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- pc_op  in  3  operation: 000 nop, 001 inc, 010 dec, 011 set, 100 add-relative, 101 call, 110 ret, 111 reserved (= nop)
- pc_arg  in  ADDR_W  absolute target (set/call) or signed two's-complement offset (add)
- op_ready  out  1  sequencer can accept pc_op this cycle
- pc_addr  out  ADDR_W  current fetch address
- fetch_valid  out  1  pc_addr is a pending fetch request
- fetch_ready  in  1  fetch stage accepts pc_addr
- ras_count  out  $clog2(RAS_DEPTH)+1  valid RAS entries
- ras_overflow  out  1  one-cycle pulse: call pushed onto a full stack
- ras_underflow  out  1  one-cycle pulse: ret issued on an empty stack

## Operation
- Reset (async assert, sync release) sets:
  - pc_addr = RESET_ADDR
  - fetch_valid = 1, so the reset vector is fetched first
  - ras_count = 0
  - ras_overflow = 0, ras_underflow = 0
- op_ready = !fetch_valid | fetch_ready (combinational). An op is accepted when op_ready is high and pc_op is not nop or reserved. pc_op is ignored when op_ready is low.
- Address update for each accepted op:
  - inc: pc_addr + STEP
  - dec: pc_addr − STEP
  - set: pc_arg
  - add: pc_addr + pc_arg (signed)
  - call: push pc_addr + STEP onto the RAS, then pc_addr ← pc_arg
  - ret: pop the top RAS entry into pc_addr
- All arithmetic is modulo 2^ADDR_W. Wrap-around is silent.
- Every accepted op, except ret on an empty stack, sets fetch_valid = 1 for the new address.
- fetch_valid clears on the cycle after the handshake (fetch_valid & fetch_ready) unless a new op is accepted in that same cycle.
- The RAS is circular. A call on a full stack overwrites the oldest entry; ras_count stays at RAS_DEPTH and ras_overflow pulses.
- A ret on an empty stack leaves pc_addr and fetch_valid unchanged, makes no fetch request, and pulses ras_underflow.
- Reset asserted mid-operation discards any pending request and clears the RAS.

## Timing
- All outputs except op_ready are registered.
- Op accepted at edge N: new pc_addr and fetch_valid = 1 are visible after edge N. Latency is one cycle.
- Back-to-back ops with fetch_ready held high give one new address per cycle.
- Handshake and new op in the same cycle: the old address is consumed, the new address becomes valid next cycle, and fetch_valid has no low gap.
- While fetch_valid=1 and fetch_ready=0, pc_addr and fetch_valid hold stable.
- ras_overflow and ras_underflow are high for exactly the cycle after the offending op.

## Configuration
- PC_SEQ_RAS_EN defined: RAS is instantiated and call/ret behave as above.
- PC_SEQ_RAS_EN undefined:
  - call and ret decode as nop and are never accepted
  - ras_count, ras_overflow and ras_underflow are tied to 0
  - no RAS storage is synthesised

## Structure
- Package pc_seq_pkg holds:
  - the pc_op encoding enum and named opcode constants
  - the op-width constant
- Sub-module pc_seq_ras holds the circular stack: push/pop/top, count, overflow/underflow flags, parameters ADDR_W and RAS_DEPTH.
- pc_seq holds the handshake, pc_addr register and arithmetic.

## Test plan
- Reset with RESET_ADDR=0x100 and fetch_ready=1 → pc_addr=0x100 with fetch_valid=1. Then inc×3 with STEP=4 → 0x104, 0x108, 0x10C on consecutive cycles.
- Stall: fetch_ready=0 with inc applied for 5 cycles → op_ready=0, pc_addr holds. Raise fetch_ready → exactly one inc is applied.
- Wrap: ADDR_W=8, set 0xFE, inc STEP=4 → 0x02. add 0xF0 (−16) from 0x05 → 0xF5.
- Call/return: from 0x20, call 0x80, then ret → 0x80 then 0x24 (STEP=4), ras_count goes 1 then 0.
- Overflow/underflow with RAS_DEPTH=2:
  - three calls → ras_overflow pulses once, ras_count=2
  - three rets → first two addresses returned (the first call's return address is lost); third ret pulses ras_underflow and leaves pc_addr unchanged with no fetch_valid
- Reset mid-stall with a full RAS → pc_addr=RESET_ADDR, ras_count=0, fetch_valid=1.
